// File: rtl/mfc_pkg.sv
// Shared types and constants for the Manchester frame receive controller.
// The RX_CRC8_EN build option selects a serial CRC-8 checksum instead of the XOR byte.
package mfc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HUNT  = 3'd1,
        RECV  = 3'd2,
        CHECK = 3'd3,
        HOLD  = 3'd4
    } mfc_state_e;

    localparam logic [7:0] BROADCAST_ADDR = 8'hFF;
    localparam logic [7:0] CRC_POLY       = 8'h07;
    localparam int         FRAME_BITS     = 32;

    // One MSB-first step of CRC-8 (feedback taken from the register MSB xor incoming bit).
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
        logic fb;
        fb = crc[7] ^ bit_in;
        return {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
    endfunction

    // Plain XOR checksum over the three payload bytes.
    function automatic logic [7:0] xor_chk(input logic [7:0] a, input logic [7:0] c, input logic [7:0] d);
        return a ^ c ^ d;
    endfunction

endpackage

// File: rtl/mfc_crc8.sv
// Serial CRC-8 accumulator (poly 0x07, init 0x00), one bit per enabled cycle.
// Only instantiated when RX_CRC8_EN is defined.
module mfc_crc8
    import mfc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [7:0] crc
);

    logic [7:0] crc_r;

    // Accumulate one message bit per enable; clear has priority so a new frame starts at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_r <= 8'h00;
        end else if (clr) begin
            crc_r <= 8'h00;
        end else if (en) begin
            crc_r <= crc8_step(crc_r, bit_in);
        end
    end

    assign crc = crc_r;

endmodule

// File: rtl/manchester_frame_ctrl.sv
// Frame-level receive controller for the Manchester decoder: holds the decoder in
// reset while disabled, hunts for the sync byte, collects addr/cmd/data/chk and
// presents accepted commands over a valid/ready handshake.
// Build option: define RX_CRC8_EN to validate frames with CRC-8 instead of XOR.
module manchester_frame_ctrl
    import mfc_pkg::*;
#(
    parameter int         OSC_FRE   = 32,
    parameter int         DATA_RATE = 2,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter logic [7:0] MY_ADDR   = 8'h03
) (
    input  logic        osc,
    input  logic        rst,
    input  logic        enable,
    input  logic        recovered_data,
    input  logic        balanced_clk,
    output logic        dec_rst_n,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_addr,
    output logic [7:0]  cmd_code,
    output logic [7:0]  cmd_data,
    output logic        err_chk,
    output logic        err_timeout,
    output logic [15:0] frame_cnt
);

    localparam int TIMEOUT = 2 * OSC_FRE / DATA_RATE;
    localparam int TMO_W   = $clog2(TIMEOUT + 1);

    mfc_state_e         state_r;
    logic               bclk_prev_r;
    logic [7:0]         sync_win_r;
    logic [FRAME_BITS-1:0] shift_r;
    logic [4:0]         bit_cnt_r;
    logic [TMO_W-1:0]   tmo_cnt_r;
    logic               dec_rst_n_r;
    logic               cmd_valid_r;
    logic [7:0]         cmd_addr_r;
    logic [7:0]         cmd_code_r;
    logic [7:0]         cmd_data_r;
    logic               err_chk_r;
    logic               err_timeout_r;
    logic [15:0]        frame_cnt_r;

    logic               strobe_s;
    logic [7:0]         sync_next_s;
    logic [FRAME_BITS-1:0] shift_next_s;
    logic               tmo_done_s;
    logic [7:0]         chk_ref_s;
    logic               chk_ok_s;
    logic               addr_ok_s;

`ifdef RX_CRC8_EN
    logic               crc_clr_s;
    logic               crc_en_s;
    logic [7:0]         crc_s;

    // CRC restarts whenever no frame is in progress and eats only the first 24 payload bits.
    always_comb begin
        crc_clr_s = (state_r == IDLE) || (state_r == HUNT);
        crc_en_s  = (state_r == RECV) && strobe_s && (bit_cnt_r < 5'd24);
    end

    mfc_crc8 u_crc8 (
        .clk    (osc),
        .rst    (rst),
        .clr    (crc_clr_s),
        .en     (crc_en_s),
        .bit_in (recovered_data),
        .crc    (crc_s)
    );
`endif

    // Bit strobe, shift previews, timeout terminal count and frame validation.
    always_comb begin
        strobe_s     = balanced_clk & ~bclk_prev_r;
        sync_next_s  = {sync_win_r[6:0], recovered_data};
        shift_next_s = {shift_r[FRAME_BITS-2:0], recovered_data};
        tmo_done_s   = (tmo_cnt_r == TMO_W'(TIMEOUT - 1));
`ifdef RX_CRC8_EN
        chk_ref_s    = crc_s;
`else
        chk_ref_s    = xor_chk(shift_r[31:24], shift_r[23:16], shift_r[15:8]);
`endif
        chk_ok_s     = (shift_r[7:0] == chk_ref_s);
        addr_ok_s    = (shift_r[31:24] == MY_ADDR) || (shift_r[31:24] == BROADCAST_ADDR);
    end

    // Frame sequencer with registered outputs; enable low overrides everything.
    always_ff @(posedge osc or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            bclk_prev_r   <= 1'b0;
            sync_win_r    <= 8'h00;
            shift_r       <= '0;
            bit_cnt_r     <= 5'd0;
            tmo_cnt_r     <= '0;
            dec_rst_n_r   <= 1'b0;
            cmd_valid_r   <= 1'b0;
            cmd_addr_r    <= 8'h00;
            cmd_code_r    <= 8'h00;
            cmd_data_r    <= 8'h00;
            err_chk_r     <= 1'b0;
            err_timeout_r <= 1'b0;
            frame_cnt_r   <= 16'h0000;
        end else begin
            bclk_prev_r   <= balanced_clk;
            err_chk_r     <= 1'b0;
            err_timeout_r <= 1'b0;
            if (!enable) begin
                state_r     <= IDLE;
                dec_rst_n_r <= 1'b0;
                cmd_valid_r <= 1'b0;
                sync_win_r  <= 8'h00;
                shift_r     <= '0;
                bit_cnt_r   <= 5'd0;
                tmo_cnt_r   <= '0;
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r     <= HUNT;
                        dec_rst_n_r <= 1'b1;
                        sync_win_r  <= 8'h00;
                    end
                    HUNT: begin
                        if (strobe_s) begin
                            if (sync_next_s == SYNC_BYTE) begin
                                state_r    <= RECV;
                                sync_win_r <= 8'h00;
                                shift_r    <= '0;
                                bit_cnt_r  <= 5'd0;
                                tmo_cnt_r  <= '0;
                            end else begin
                                sync_win_r <= sync_next_s;
                            end
                        end
                    end
                    RECV: begin
                        // A strobe coinciding with the terminal count keeps the frame alive.
                        if (strobe_s) begin
                            shift_r   <= shift_next_s;
                            tmo_cnt_r <= '0;
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                            if (bit_cnt_r == 5'd31) begin
                                state_r <= CHECK;
                            end
                        end else if (tmo_done_s) begin
                            err_timeout_r <= 1'b1;
                            tmo_cnt_r     <= '0;
                            state_r       <= HUNT;
                        end else begin
                            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                        end
                    end
                    CHECK: begin
                        if (!chk_ok_s) begin
                            err_chk_r <= 1'b1;
                            state_r   <= HUNT;
                        end else if (!addr_ok_s) begin
                            state_r <= HUNT;
                        end else begin
                            cmd_addr_r  <= shift_r[31:24];
                            cmd_code_r  <= shift_r[23:16];
                            cmd_data_r  <= shift_r[15:8];
                            frame_cnt_r <= frame_cnt_r + 16'd1;
                            cmd_valid_r <= 1'b1;
                            state_r     <= HOLD;
                        end
                    end
                    HOLD: begin
                        // Line strobes are ignored here; only the handshake moves on.
                        if (cmd_valid_r && cmd_ready) begin
                            cmd_valid_r <= 1'b0;
                            sync_win_r  <= 8'h00;
                            state_r     <= HUNT;
                        end
                    end
                    default: begin
                        state_r     <= IDLE;
                        dec_rst_n_r <= 1'b0;
                        cmd_valid_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign dec_rst_n   = dec_rst_n_r;
    assign cmd_valid   = cmd_valid_r;
    assign cmd_addr    = cmd_addr_r;
    assign cmd_code    = cmd_code_r;
    assign cmd_data    = cmd_data_r;
    assign err_chk     = err_chk_r;
    assign err_timeout = err_timeout_r;
    assign frame_cnt   = frame_cnt_r;

endmodule

// File: tb/tb_manchester_frame_ctrl.sv
// Directed, scoreboard-driven bench for manchester_frame_ctrl. Each sent frame pushes
// its expected outcome; the outcome checker pops it and checks cycle-exact behaviour.
module tb_manchester_frame_ctrl;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int K_ACCEPT  = 0;
    localparam int K_ERRCHK  = 1;
    localparam int K_SILENT  = 2;
    localparam int K_TIMEOUT = 3;

    typedef struct {
        int         kind;
        logic [7:0] a;
        logic [7:0] c;
        logic [7:0] d;
    } exp_t;

    logic        osc = 1'b0;
    logic        rst;
    logic        enable;
    logic        recovered_data;
    logic        balanced_clk;
    logic        dec_rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_addr;
    logic [7:0]  cmd_code;
    logic [7:0]  cmd_data;
    logic        err_chk;
    logic        err_timeout;
    logic [15:0] frame_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_frame_cnt = 16'd0;
    exp_t        sb_q[$];

    always #5 osc = ~osc;

    manchester_frame_ctrl dut (
        .osc            (osc),
        .rst            (rst),
        .enable         (enable),
        .recovered_data (recovered_data),
        .balanced_clk   (balanced_clk),
        .dec_rst_n      (dec_rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_addr       (cmd_addr),
        .cmd_code       (cmd_code),
        .cmd_data       (cmd_data),
        .err_chk        (err_chk),
        .err_timeout    (err_timeout),
        .frame_cnt      (frame_cnt)
    );

    function automatic logic [7:0] good_chk(input logic [7:0] a, input logic [7:0] c, input logic [7:0] d);
`ifdef RX_CRC8_EN
        logic [23:0] m;
        logic [7:0]  r;
        logic        fb;
        m = {a, c, d};
        r = 8'h00;
        for (int i = 23; i >= 0; i--) begin
            fb = r[7] ^ m[i];
            r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return r;
`else
        return a ^ c ^ d;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One bit: strobe edge follows the first negedge; ends at the negedge after it (+gap).
    task automatic send_bit(input logic b, input int gap);
        @(negedge osc);
        recovered_data = b;
        balanced_clk   = 1'b1;
        @(negedge osc);
        balanced_clk   = 1'b0;
        repeat (gap) @(negedge osc);
    endtask

    // Sends v[n-1:0] MSB first; returns in the cycle right after the last strobe.
    task automatic send_bits(input logic [39:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(v[i], (i == 0) ? 0 : 1);
        end
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] c, input logic [7:0] d,
                              input logic [7:0] k, input int kind);
        exp_t e;
        e.kind = kind; e.a = a; e.c = c; e.d = d;
        sb_q.push_back(e);
        send_bits({SYNC, a, c, d, k}, 40);
    endtask

    // Called in the cycle after the last strobe (N+1); pops and checks the expected outcome.
    task automatic check_outcome(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_n1_valid"}, {31'd0, cmd_valid}, 32'd0);
            if (e.kind == K_TIMEOUT) begin
                repeat (31) @(negedge osc);
                chk({tag, "_tmo_early"}, {31'd0, err_timeout}, 32'd0);
                @(negedge osc);
                chk({tag, "_tmo_pulse"}, {31'd0, err_timeout}, 32'd1);
                chk({tag, "_tmo_valid"}, {31'd0, cmd_valid}, 32'd0);
                @(negedge osc);
                chk({tag, "_tmo_end"}, {31'd0, err_timeout}, 32'd0);
            end else begin
                if (e.kind == K_ACCEPT) exp_frame_cnt = exp_frame_cnt + 16'd1;
                @(negedge osc);
                chk({tag, "_valid"}, {31'd0, cmd_valid}, (e.kind == K_ACCEPT) ? 32'd1 : 32'd0);
                chk({tag, "_errchk"}, {31'd0, err_chk}, (e.kind == K_ERRCHK) ? 32'd1 : 32'd0);
                chk({tag, "_fcnt"}, {16'd0, frame_cnt}, {16'd0, exp_frame_cnt});
                if (e.kind == K_ACCEPT) begin
                    chk({tag, "_addr"}, {24'd0, cmd_addr}, {24'd0, e.a});
                    chk({tag, "_code"}, {24'd0, cmd_code}, {24'd0, e.c});
                    chk({tag, "_data"}, {24'd0, cmd_data}, {24'd0, e.d});
                end
                @(negedge osc);
                chk({tag, "_errchk_end"}, {31'd0, err_chk}, 32'd0);
                chk({tag, "_valid_n3"}, {31'd0, cmd_valid},
                    ((e.kind == K_ACCEPT) && !cmd_ready) ? 32'd1 : 32'd0);
            end
        end
    endtask

    initial begin
        int seen;
        rst            = 1'b1;
        enable         = 1'b0;
        recovered_data = 1'b0;
        balanced_clk   = 1'b0;
        cmd_ready      = 1'b1;
        repeat (3) @(negedge osc);
        chk("rst_dec_rst_n", {31'd0, dec_rst_n}, 32'd0);
        chk("rst_valid",     {31'd0, cmd_valid}, 32'd0);
        chk("rst_fields",    {8'd0, cmd_addr, cmd_code, cmd_data}, 32'd0);
        chk("rst_errs",      {30'd0, err_chk, err_timeout}, 32'd0);
        chk("rst_fcnt",      {16'd0, frame_cnt}, 32'd0);
        rst = 1'b0;
        @(negedge osc);
        chk("idle_dec_rst_n", {31'd0, dec_rst_n}, 32'd0);
        enable = 1'b1;
        @(negedge osc);
        chk("en_dec_rst_n", {31'd0, dec_rst_n}, 32'd1);

        // Normal accept, bad checksum, foreign address, broadcast.
        send_frame(8'h03, 8'h10, 8'h7F, good_chk(8'h03, 8'h10, 8'h7F), K_ACCEPT);
        check_outcome("good1");
        send_frame(8'h03, 8'h10, 8'h7F, good_chk(8'h03, 8'h10, 8'h7F) ^ 8'h01, K_ERRCHK);
        check_outcome("badchk");
        send_frame(8'h04, 8'h10, 8'h7F, good_chk(8'h04, 8'h10, 8'h7F), K_SILENT);
        check_outcome("foreign");
        send_frame(8'hFF, 8'h10, 8'h7F, good_chk(8'hFF, 8'h10, 8'h7F), K_ACCEPT);
        check_outcome("bcast");

        // Truncated frame: sync plus 12 payload bits, then silence.
        sb_q.push_back('{kind: K_TIMEOUT, a: 8'h00, c: 8'h00, d: 8'h00});
        send_bits({20'd0, SYNC, 12'hC3A}, 20);
        check_outcome("timeout");
        send_frame(8'h03, 8'h22, 8'h5A, good_chk(8'h03, 8'h22, 8'h5A), K_ACCEPT);
        check_outcome("after_tmo");

        // Consumer stalls; line activity during HOLD must not disturb the command.
        cmd_ready = 1'b0;
        send_frame(8'h03, 8'h31, 8'hC4, good_chk(8'h03, 8'h31, 8'hC4), K_ACCEPT);
        check_outcome("hold");
        send_bits({SYNC, 8'h03, 8'h99, 8'h11, good_chk(8'h03, 8'h99, 8'h11)}, 40);
        repeat (5) @(negedge osc);
        chk("hold_valid", {31'd0, cmd_valid}, 32'd1);
        chk("hold_fields", {8'd0, cmd_addr, cmd_code, cmd_data}, {8'd0, 8'h03, 8'h31, 8'hC4});
        chk("hold_fcnt", {16'd0, frame_cnt}, {16'd0, exp_frame_cnt});
        cmd_ready = 1'b1;
        @(negedge osc);
        chk("hold_release", {31'd0, cmd_valid}, 32'd0);
        send_frame(8'hFF, 8'h05, 8'h06, good_chk(8'hFF, 8'h05, 8'h06), K_ACCEPT);
        check_outcome("post_hold");

        // Drop enable in the middle of a frame; no late pulses may appear.
        send_bits({22'd0, SYNC, 10'h2B5}, 18);
        enable = 1'b0;
        @(negedge osc);
        chk("dis_dec_rst_n", {31'd0, dec_rst_n}, 32'd0);
        chk("dis_valid",     {31'd0, cmd_valid}, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge osc);
            if (err_timeout || err_chk) seen++;
        end
        chk("dis_no_pulse", seen, 32'd0);
        enable = 1'b1;
        @(negedge osc);
        chk("reen_dec_rst_n", {31'd0, dec_rst_n}, 32'd1);

        // Asynchronous reset while a command is held.
        cmd_ready = 1'b0;
        send_frame(8'h03, 8'h44, 8'h55, good_chk(8'h03, 8'h44, 8'h55), K_ACCEPT);
        check_outcome("pre_rst");
        @(negedge osc);
        rst = 1'b1;
        #1;
        chk("arst_dec_rst_n", {31'd0, dec_rst_n}, 32'd0);
        chk("arst_valid",     {31'd0, cmd_valid}, 32'd0);
        chk("arst_fcnt",      {16'd0, frame_cnt}, 32'd0);
        chk("arst_addr",      {24'd0, cmd_addr}, 32'd0);
        exp_frame_cnt = 16'd0;
        @(negedge osc);
        rst       = 1'b0;
        cmd_ready = 1'b1;
        @(negedge osc);
        chk("post_rst_dec_rst_n", {31'd0, dec_rst_n}, 32'd1);
        send_frame(8'h03, 8'h10, 8'h7F, good_chk(8'h03, 8'h10, 8'h7F), K_ACCEPT);
        check_outcome("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/manchester_frame_ctrl.md
# manchester_frame_ctrl

Frame-level receive controller for the LED control processor's Manchester decoder. Sequences the decoder: holds it in reset while disabled, releases it when enabled, and turns its recovered bitstream and bit clock into validated command frames. Each frame is sync byte, address, command, data and checksum. Accepted commands are presented to the LED command logic through a valid/ready handshake.

## Interface
- OSC_FRE, 32, oscillator frequency in MHz
- DATA_RATE, 2, Manchester bit rate in Mbit/s
- SYNC_BYTE, 8'hA5, frame start pattern
- MY_ADDR, 8'h03, node address; 8'hFF is always accepted as broadcast
- osc  in  1  system clock; the only clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  level; low holds the decoder in reset and the controller in IDLE
- recovered_data  in  1  decoder data output
- balanced_clk  in  1  decoder bit clock, synchronous to osc
- dec_rst_n  out  1  active-low reset to the decoder
- cmd_valid  out  1  command available
- cmd_ready  in  1  consumer accepts the command
- cmd_addr, cmd_code, cmd_data  out  8 each  accepted frame fields
- err_chk  out  1  one-cycle pulse: checksum mismatch
- err_timeout  out  1  one-cycle pulse: bit gap inside a frame
- frame_cnt  out  16  accepted-frame counter, wraps at 16'hFFFF to 0

## Operation
- Bit strobe: one-cycle pulse on a detected rising edge of balanced_clk (previous value is registered). recovered_data is sampled in the strobe cycle. Frames are MSB first.
- States:
  - IDLE: dec_rst_n=0, all windows cleared. enable=1 → HUNT; dec_rst_n goes high in the same registered update.
  - HUNT: an 8-bit sliding window shifts on each strobe. A window equal to SYNC_BYTE after a shift → RECV, with bit_cnt=0.
  - RECV: a 32-bit shift register takes one bit per strobe; bit_cnt counts 0..31. The 32nd strobe → CHECK.
  - CHECK (one cycle): checksum is OK if chk == addr^cmd^data. If it fails: pulse err_chk → HUNT. If addr is neither MY_ADDR nor 8'hFF: → HUNT silently, no error. Otherwise latch the fields, increment frame_cnt → HOLD.
  - HOLD: cmd_valid=1 and the fields stay stable until cmd_valid&&cmd_ready; then → HUNT. Strobes during HOLD are discarded; the sync window is cleared on exit.
- Timeout: TIMEOUT = 2*OSC_FRE/DATA_RATE osc cycles (32 at defaults). The counter is width $clog2(TIMEOUT+1) and resets on every strobe; it runs only in RECV. Reaching TIMEOUT pulses err_timeout and → HUNT, discarding the partial frame.
- enable low in any state → IDLE next cycle. This aborts the frame and drops cmd_valid without a handshake. Pending pulses are suppressed.
- A strobe in the same cycle as the timeout terminal count wins: the bit is taken and the counter is cleared.

## Timing
- Reset values: dec_rst_n=0, cmd_valid=0, cmd_addr/cmd_code/cmd_data=0, err_chk=0, err_timeout=0, frame_cnt=0; state IDLE.
- Last checksum strobe in cycle N: CHECK in N+1, cmd_valid high from N+2, err_chk pulses in N+2.
- Handshake completes in cycle M: cmd_valid low in M+1. No back-to-back frames without a re-sync.
- All outputs are registered.

## Configuration
- RX_CRC8_EN defined: checksum is CRC-8, polynomial 0x07, init 0x00, computed serially over the 24 addr/cmd/data bits as they arrive. CHECK compares the CRC register with the chk byte; latency is unchanged.
- RX_CRC8_EN undefined: XOR checksum as above; no CRC logic is built.

## Structure
- Package mfc_pkg: state enum (IDLE, HUNT, RECV, CHECK, HOLD), BROADCAST_ADDR=8'hFF, CRC_POLY=8'h07, FRAME_BITS=32.
- Sub-module mfc_crc8: serial CRC-8 with clear/shift enable. Instantiated only under RX_CRC8_EN.

## Test plan
All scenarios use the XOR build unless stated otherwise.
- Enable after reset, send A5 03 10 7F 6C → cmd_valid two cycles after the last strobe with addr=03, code=10, data=7F; frame_cnt=1.
- Send A5 03 10 7F 6D → err_chk pulses for exactly one cycle; no cmd_valid; frame_cnt unchanged.
- Send A5 04 10 7F 6B → no cmd_valid and no error. Send A5 FF 10 7F 90 → accepted as broadcast.
- Send A5 followed by only 12 payload bits, then idle → err_timeout 32 cycles after the last strobe; back in HUNT; the next good frame is accepted.
- Hold cmd_ready=0 for 100 cycles after a good frame → cmd_valid and the fields stay stable; interleaved line bits are ignored; valid drops the cycle after ready=1.
- Deassert enable mid-RECV, and separately assert rst mid-HOLD → dec_rst_n=0 and cmd_valid=0 the next cycle (immediately for rst). With RX_CRC8_EN, A5 03 10 7F plus the CRC-8 byte is accepted.
